// File: rtl/nrisc_multicycle_ctrl_pkg.sv
// Shared encodings for the nRisc multicycle controller: states, opcodes, writeback mux codes.
package nrisc_multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SLL   = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_LOAD  = 3'd3;
  localparam logic [2:0] OP_ADDI  = 3'd4;
  localparam logic [2:0] OP_BEQ   = 3'd5;
  localparam logic [2:0] OP_SLT   = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  localparam logic [1:0] RS_MEM = 2'd0;
  localparam logic [1:0] RS_ALU = 2'd1;
  localparam logic [1:0] RS_SLT = 2'd2;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       ula_src1;
    logic       ula_src2;
    logic [1:0] reg_src;
    logic       slt;
    logic [1:0] beq_regs;
  } ctrl_t;

endpackage

// File: rtl/nrisc_multicycle_ctrl_decode.sv
// Opcode to datapath control decode; purely combinational, unknown opcodes give all-zero controls.
module nrisc_multicycle_ctrl_decode
  import nrisc_multicycle_ctrl_pkg::*;
(
  input  logic [2:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_ADD:   ctrl = '{alu_op: 3'd0, ula_src1: 1'b0, ula_src2: 1'b1, reg_src: RS_ALU, slt: 1'b1, beq_regs: 2'd0};
      OP_SLL:   ctrl = '{alu_op: 3'd0, ula_src1: 1'b1, ula_src2: 1'b0, reg_src: RS_ALU, slt: 1'b1, beq_regs: 2'd0};
      OP_STORE: ctrl = '{alu_op: 3'd1, ula_src1: 1'b0, ula_src2: 1'b0, reg_src: RS_MEM, slt: 1'b1, beq_regs: 2'd0};
      OP_LOAD:  ctrl = '{alu_op: 3'd0, ula_src1: 1'b0, ula_src2: 1'b0, reg_src: RS_MEM, slt: 1'b1, beq_regs: 2'd0};
      OP_ADDI:  ctrl = '{alu_op: 3'd0, ula_src1: 1'b1, ula_src2: 1'b1, reg_src: RS_ALU, slt: 1'b1, beq_regs: 2'd0};
      OP_BEQ:   ctrl = '{alu_op: 3'd0, ula_src1: 1'b0, ula_src2: 1'b0, reg_src: RS_MEM, slt: 1'b1, beq_regs: 2'd0};
      OP_SLT:   ctrl = '{alu_op: 3'd0, ula_src1: 1'b1, ula_src2: 1'b1, reg_src: RS_SLT, slt: 1'b0, beq_regs: 2'd1};
      default:  ctrl = '0;
    endcase
  end

endmodule

// File: rtl/nrisc_multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit nRisc core.
// Strobes are decoded from registered state and gated by enable; retired counts completed instructions.
module nrisc_multicycle_ctrl
  import nrisc_multicycle_ctrl_pkg::*;
#(
  parameter int INSTR_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               resume,
  input  logic [INSTR_W-1:0] instr,
  input  logic               mem_ready,
  input  logic               alu_zero,
  output logic               pc_write,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic [2:0]         alu_op,
  output logic               ula_src1,
  output logic               ula_src2,
  output logic [1:0]         reg_src,
  output logic               branch,
  output logic               slt,
  output logic [1:0]         beq_regs,
  output logic               halted,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   retired
);

  state_t     st;
  logic [2:0] opcode;
  ctrl_t      dec;
  logic       act;
  logic       ctl_on;
  logic       unused_instr;

  assign unused_instr = ^instr[INSTR_W-4:0];

  nrisc_multicycle_ctrl_decode u_decode (
    .opcode (opcode),
    .ctrl   (dec)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st      <= S_FETCH;
      opcode  <= '0;
      retired <= '0;
    end else if (enable) begin
      case (st)
        S_FETCH: begin
          if (mem_ready) begin
            opcode <= instr[INSTR_W-1 -: 3];
            st     <= S_DECODE;
          end
        end
        // Anything not a known executable opcode (including X/Z in simulation) halts.
        S_DECODE: begin
          case (opcode)
            OP_ADD, OP_SLL, OP_STORE, OP_LOAD, OP_ADDI, OP_BEQ, OP_SLT: st <= S_EXEC;
            default: st <= S_HALTED;
          endcase
        end
        S_EXEC: begin
          case (opcode)
            OP_STORE, OP_LOAD: st <= S_MEM;
            OP_BEQ: begin
              st      <= S_FETCH;
              retired <= retired + CNT_W'(1);
            end
            default: st <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (opcode == OP_STORE) begin
              st      <= S_FETCH;
              retired <= retired + CNT_W'(1);
            end else begin
              st <= S_WB;
            end
          end
        end
        S_WB: begin
          st      <= S_FETCH;
          retired <= retired + CNT_W'(1);
        end
        S_HALTED: begin
          if (resume) st <= S_FETCH;
        end
        default: st <= S_FETCH;
      endcase
    end
  end

  // Gating with reset keeps an in-flight write from being seen while reset is held.
  assign act = enable & ~reset;

  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    branch    = 1'b0;
    case (st)
      S_FETCH: begin
        mem_read = act;
        ir_write = act & mem_ready;
        pc_write = act & mem_ready;
      end
      S_EXEC: begin
        if (opcode == OP_BEQ) begin
          branch   = act;
          pc_write = act & alu_zero;
        end
      end
      S_MEM: begin
        mem_write = act & (opcode == OP_STORE);
        mem_read  = act & (opcode == OP_LOAD);
      end
      S_WB:    reg_write = act;
      default: ;
    endcase
  end

  assign ctl_on   = (st == S_EXEC) || (st == S_MEM) || (st == S_WB);
  assign alu_op   = ctl_on ? dec.alu_op   : 3'd0;
  assign ula_src1 = ctl_on ? dec.ula_src1 : 1'b0;
  assign ula_src2 = ctl_on ? dec.ula_src2 : 1'b0;
  assign reg_src  = ctl_on ? dec.reg_src  : 2'd0;
  assign slt      = ctl_on ? dec.slt      : 1'b0;
  assign beq_regs = ctl_on ? dec.beq_regs : 2'd0;
  assign halted   = (st == S_HALTED);
  assign state    = st;

endmodule
